// File: rtl/rca_seq_if.sv
// Operand/result bundle for the segmented ripple-carry adder.
// master drives the request side, slave is the adder.
interface rca_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             Ovf;

  modport master (
    output start, sub, cin, A, B,
    input  busy, done, Sum, Cout, Ovf
  );

  modport slave (
    input  start, sub, cin, A, B,
    output busy, done, Sum, Cout, Ovf
  );
endinterface

// File: rtl/rca_seq.sv
// Multi-cycle segmented ripple-carry adder/subtractor: one CHUNK-bit slice per clock,
// LSB slice first, carry held in a register between slices.
//
// Handshake: start is sampled only in IDLE or DONE; busy is high exactly in RUN and
// start is ignored there (no queueing); done is a one-cycle pulse in the cycle after
// the last slice, when Sum/Cout/Ovf have just been updated.
module rca_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  rca_seq_if.slave   bus,
  output logic [1:0] dbg_state
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = $clog2(NCHUNK) + 1;
  localparam logic [WIDTH-1:0] SLICE_MASK = {WIDTH{1'b1}} >> (WIDTH - CHUNK);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic [IDXW-1:0]   idx_q, idx_d;

  int unsigned       sh;
  logic [WIDTH-1:0]  a_sh, b_sh, slice_w, acc_ins;
  logic [CHUNK:0]    slice_sum;
  logic              carry_into_msb;
  logic              last_slice;

  // Slice datapath: select the current slice by shifting, add with the carry register.
  always_comb begin
    sh             = 32'(idx_q) * CHUNK;
    a_sh           = a_q >> sh;
    b_sh           = b_q >> sh;
    slice_sum      = {1'b0, a_sh[CHUNK-1:0]} + {1'b0, b_sh[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
    slice_w        = '0;
    slice_w[CHUNK-1:0] = slice_sum[CHUNK-1:0];
    acc_ins        = (acc_q & ~(SLICE_MASK << sh)) | (slice_w << sh);
    // carry into a bit position = a ^ b ^ sum at that position
    carry_into_msb = a_sh[CHUNK-1] ^ b_sh[CHUNK-1] ^ slice_sum[CHUNK-1];
    last_slice     = (idx_q == IDXW'(NCHUNK - 1));
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_d     = bus.A;
          b_d     = bus.B ^ {WIDTH{bus.sub}};
          carry_d = bus.sub ? 1'b1 : bus.cin;
          idx_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d   = acc_ins;
        carry_d = slice_sum[CHUNK];
        idx_d   = idx_q + 1'b1;
        if (last_slice) begin
          sum_d   = acc_ins;
          cout_d  = slice_sum[CHUNK];
          ovf_d   = carry_into_msb ^ slice_sum[CHUNK];
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.busy  = (state_q == RUN);
  assign bus.done  = (state_q == DONE);
  assign bus.Sum   = sum_q;
  assign bus.Cout  = cout_q;
  assign bus.Ovf   = ovf_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_rca_seq.sv
// Directed bench for rca_seq at WIDTH=16, CHUNK=4: hand-computed sums, latency,
// busy/done handshake, start-while-busy, back-to-back start and mid-operation reset.
module tb_rca_seq;
  localparam int WIDTH = 16;
  localparam int CHUNK = 4;
  localparam int LAT   = WIDTH / CHUNK + 1;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         checks;
  int         errors;

  rca_seq_if #(.WIDTH(WIDTH)) bus_if ();

  rca_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus_if),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Waits (at negedges) for done; lat counts negedges after the start edge.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (bus_if.done === 1'b1) return;
    end
    lat = -1;
  endtask

  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic sub,
                       input logic [15:0] exp_sum, input logic exp_cout, input logic exp_ovf);
    int lat;
    @(negedge clk);
    bus_if.A     = a;
    bus_if.B     = b;
    bus_if.cin   = cin;
    bus_if.sub   = sub;
    bus_if.start = 1'b1;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    // scramble inputs after the start edge; the op in flight must not see them
    bus_if.A   = 16'($urandom_range(0, 65535));
    bus_if.B   = 16'($urandom_range(0, 65535));
    bus_if.cin = ~cin;
    bus_if.sub = ~sub;
    wait_done(lat);
    check({tag, "_lat"}, 32'(lat), 32'(LAT));
    check({tag, "_sum"}, 32'(bus_if.Sum), 32'(exp_sum));
    check({tag, "_cout"}, 32'(bus_if.Cout), 32'(exp_cout));
    check({tag, "_ovf"}, 32'(bus_if.Ovf), 32'(exp_ovf));
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(bus_if.done), 32'd0);
    check({tag, "_hold"}, 32'(bus_if.Sum), 32'(exp_sum));
  endtask

  initial begin
    int lat;
    int lat2;
    logic saw_done;
    checks = 0;
    errors = 0;
    rst_n        = 1'b0;
    bus_if.start = 1'b0;
    bus_if.sub   = 1'b0;
    bus_if.cin   = 1'b0;
    bus_if.A     = '0;
    bus_if.B     = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", 32'(bus_if.busy), 32'd0);
    check("rst_done", 32'(bus_if.done), 32'd0);
    check("rst_sum", 32'(bus_if.Sum), 32'd0);
    check("rst_cout", 32'(bus_if.Cout), 32'd0);
    check("rst_ovf", 32'(bus_if.Ovf), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);

    do_op("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    do_op("add_ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op("add_ovf", 16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);
    do_op("sub_neg", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    do_op("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    do_op("add_cin", 16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);

    // start held through RUN with changing operands, then back-to-back from DONE
    @(negedge clk);
    bus_if.A = 16'h0001; bus_if.B = 16'h0002; bus_if.cin = 1'b0; bus_if.sub = 1'b0;
    bus_if.start = 1'b1;
    @(posedge clk);
    #1;
    bus_if.A = 16'h0010; bus_if.B = 16'h0020;
    @(negedge clk);
    check("busy_in_run", 32'(bus_if.busy), 32'd1);
    wait_done(lat);
    check("b2b_first_lat", 32'(lat), 32'(LAT - 1));
    check("b2b_first_sum", 32'(bus_if.Sum), 32'h0003);
    check("b2b_busy_in_done", 32'(bus_if.busy), 32'd0);
    wait_done(lat2);
    bus_if.start = 1'b0;
    check("b2b_period", 32'(lat2), 32'(LAT));
    check("b2b_second_sum", 32'(bus_if.Sum), 32'h0030);

    // reset at the second RUN edge aborts without done
    do_op("pre_rst", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    @(negedge clk);
    bus_if.A = 16'h1111; bus_if.B = 16'h2222; bus_if.start = 1'b1;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(bus_if.busy), 32'd0);
    check("abort_sum", 32'(bus_if.Sum), 32'd0);
    check("abort_cout", 32'(bus_if.Cout), 32'd0);
    check("abort_ovf", 32'(bus_if.Ovf), 32'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus_if.done === 1'b1) saw_done = 1'b1;
    end
    check("abort_no_done", 32'(saw_done), 32'd0);
    do_op("post_rst", 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
